// File: rtl/snn_frame_sequencer.sv
// Frame sequencer for the 16-neuron NVM block. It snapshots a frame of axon spikes,
// fetches the synapse row of each spiking axon and integrates it, then latches the result.
module snn_frame_sequencer #(
  parameter int                 NUM_AXONS = 256,
  parameter int                 NUM_EXC   = 128,
  parameter logic signed [15:0] W_EXC     = 16'sd1,
  parameter logic signed [15:0] W_INH     = 16'sd1,
  parameter int                 AW        = $clog2(NUM_AXONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_AXONS-1:0] axon_spikes,
  output logic                 busy,
  output logic                 syn_req,
  output logic [AW-1:0]        syn_addr,
  input  logic                 syn_ack,
  input  logic [15:0]          syn_conn,
  output logic signed [15:0]   nb_stimuli,
  output logic [15:0]          nb_connection,
  output logic                 nb_enable,
  output logic                 nb_picture_done,
  input  logic [15:0]          nb_spike,
  output logic [15:0]          spike_out,
  output logic                 done
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT, S_LATCH, S_CLEAR} state_t;

  localparam logic [AW-1:0]      LAST_IDX = AW'(NUM_AXONS - 1);
  localparam logic signed [15:0] STIM_INH = -W_INH;

  state_t                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [NUM_AXONS-1:0]   axon_q, axon_d;
  logic [15:0]            spike_q, spike_d;
  logic                   done_q, done_d;

  logic last, is_exc, fire;

  assign last   = (idx_q == LAST_IDX);
  assign is_exc = (32'(idx_q) < NUM_EXC);
  assign fire   = (state_q == S_WAIT) && syn_ack;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    axon_d  = axon_q;
    spike_d = spike_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        axon_d  = axon_spikes;
        idx_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (axon_q[idx_q])  state_d = S_WAIT;
        else if (last)      state_d = S_LATCH;
        else                idx_d   = idx_q + AW'(1);
      end
      // the neuron block integrates on the same edge that retires the request
      S_WAIT: if (syn_ack) begin
        if (last) state_d = S_LATCH;
        else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_SCAN;
        end
      end
      S_LATCH: begin
        spike_d = nb_spike;
        done_d  = 1'b1;
        state_d = S_CLEAR;
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      axon_q  <= '0;
      spike_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      axon_q  <= axon_d;
      spike_q <= spike_d;
      done_q  <= done_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign syn_req         = (state_q == S_WAIT);
  assign syn_addr        = idx_q;
  assign nb_enable       = fire;
  assign nb_connection   = fire ? syn_conn : 16'h0000;
  assign nb_stimuli      = (state_q == S_WAIT) ? (is_exc ? W_EXC : STIM_INH) : 16'sd0;
  assign nb_picture_done = (state_q == S_CLEAR);
  assign spike_out       = spike_q;
  assign done            = done_q;

endmodule

// File: doc/snn_frame_sequencer.md
# snn_frame_sequencer

Frame-level controller for the 16-neuron NVM neuron block. On `start` it snapshots one frame of input axon spikes, and walks every axon in index order. For each spiking axon it fetches that axon's 16-bit connection row from the synapse matrix over a req/ack handshake. It then drives the neuron block's `stimuli`/`connection`/`enable` inputs to integrate the axon's contribution. After the last axon it latches the 16 neuron spikes as the frame result, then pulses the neuron block's `picture_done` to clear the membrane potentials for the next frame.

## Interface
Parameters:
- `NUM_AXONS`, 256, number of input axons per frame; must be ≥2.
- `NUM_EXC`, 128, axons `0..NUM_EXC-1` are excitatory; the rest are inhibitory.
- `W_EXC`, 16'sd1, signed stimulus for an excitatory axon (positive).
- `W_INH`, 16'sd1, magnitude of the stimulus for an inhibitory axon; it is driven as `-W_INH`.
- `AW`, `$clog2(NUM_AXONS)`, width of the axon index and synapse address.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high; shared with the neuron block.
- `start`  in  1  frame request pulse; accepted only in IDLE.
- `axon_spikes`  in  NUM_AXONS  input spike vector; sampled on the accepting edge.
- `busy`  out  1  high in every state except IDLE.
- `syn_req`  out  1  synapse read request.
- `syn_addr`  out  AW  synapse row address, equal to the current axon index.
- `syn_ack`  in  1  synapse read acknowledge; `syn_conn` is valid while it is high.
- `syn_conn`  in  16  connection row, one bit per neuron.
- `nb_stimuli`  out  16 signed  stimulus to the neuron block.
- `nb_connection`  out  16  connection mask to the neuron block.
- `nb_enable`  out  1  integrate strobe to the neuron block.
- `nb_picture_done`  out  1  potential clear to the neuron block.
- `nb_spike`  in  16  neuron spike outputs; spike = sign bit of the potential clear.
- `spike_out`  out  16  registered frame result.
- `done`  out  1  one-cycle frame-complete pulse.

## Operation
- States: IDLE, SCAN, WAIT, LATCH, CLEAR. Encode freely.
- IDLE:
  - If `start`=1: `axon_q<=axon_spikes`, `idx<=0`, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - If `axon_q[idx]`=1: go to WAIT.
  - Else if `idx`==NUM_AXONS-1: go to LATCH.
  - Else `idx<=idx+1` and stay in SCAN.
  - Non-spiking axons cost exactly 1 cycle each.
- WAIT:
  - `syn_req`=1 and `syn_addr`=`idx`, both held stable until ack.
  - On `syn_ack`=1, in the same cycle: `nb_enable`=1 and `nb_connection`=`syn_conn`.
  - On that edge: if `idx`==NUM_AXONS-1 go to LATCH; else `idx<=idx+1` and go to SCAN.
  - Ack is allowed in the first WAIT cycle (zero-wait slave).
- `nb_stimuli`:
  - `idx`<NUM_EXC: `W_EXC`.
  - Otherwise: `-W_INH` (two's complement, 16-bit).
  - Valid whenever `nb_enable`=1; don't-care otherwise.
- `nb_enable` and `nb_connection` are gated to 0 outside WAIT&`syn_ack`.
- `syn_ack` outside WAIT is ignored.
- LATCH:
  - `spike_out<=nb_spike`, `done<=1` (registered), go to CLEAR.
  - The last integration is already registered in the neuron block by this cycle.
- CLEAR:
  - `nb_picture_done`=1 (decoded from state), `done`=1, go to IDLE.
- `start` outside IDLE, including during CLEAR, is ignored and not queued.
- Changes on `axon_spikes` after the accepting edge have no effect on the current frame.
- `spike_out` holds its value until the next LATCH.
- Reset values:
  - State IDLE, `idx`=0, `axon_q`=0, `spike_out`=0.
  - `done`, `busy`, `syn_req`, `nb_enable`, `nb_picture_done` = 0.
  - `syn_addr`=0, `nb_connection`=0, `nb_stimuli`=0.
- Reset mid-frame: all of the above take effect immediately (asynchronously). The frame is abandoned with no `done`, and the neuron block is cleared by the same `rst`.

## Timing
- Start accepted at edge 0.
- `done` is high in the cycle after edge NUM_AXONS+1 + Σ(WAIT cycles), where each spiking axon adds its WAIT cycles (≥1).
- All-zero frame: `done` is high in the cycle after edge NUM_AXONS+1, i.e. after edge 257 at defaults.
- `busy` rises after edge 0 and falls after the CLEAR cycle.
- `done` and `nb_picture_done` are coincident, one cycle each.
- A new `start` is accepted from the first IDLE cycle after CLEAR.
- `nb_enable` pulses are exactly 1 cycle, one per spiking axon, in ascending axon order.

## Test plan
- Reset: hold `rst` for 3 cycles → every output 0 and `busy`=0; `start` during reset is ignored.
- All-zero frame, defaults: `start` → no `syn_req`, no `nb_enable`; `done` high in the cycle after edge 257; `spike_out`=16'hFFFF (potentials 0).
- Axon 5 spiking only, slave acks 3 cycles after `syn_req` rises with `syn_conn`=16'h0001 → `syn_addr`=5 stable during the request; one `nb_enable` pulse with `nb_stimuli`=+1 and `nb_connection`=16'h0001; `done` delayed by 4 cycles versus the all-zero frame; `spike_out`=16'hFFFF.
- Axon 200 spiking only (inhibitory), zero-wait ack with `syn_conn`=16'h8001 → `nb_stimuli`=16'hFFFF; `spike_out`=16'h7FFE. A following all-zero frame gives `spike_out`=16'hFFFF, proving `nb_picture_done` cleared the potentials.
- Axons 0 and 255 both spiking, acks `syn_conn`=16'h0003 then 16'h0002 → two `nb_enable` pulses in order with addresses 0 then 255; `spike_out`=16'hFFFF; LATCH is reached directly from WAIT on idx 255.
- `start` pulsed during SCAN and during CLEAR → ignored, single `done`; `rst` asserted while in WAIT with `syn_req`=1 → `syn_req` and `busy` drop without waiting for a clock edge, no `done`; a subsequent `start` runs a normal frame.
